seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_if.sv | 15 +
 rtl/seg_scan_driver.sv | 118 +++++++++++
 tb/tb_seg_scan_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus bundle between a display controller and seg_scan_driver: shadow-load
// request with hex value and decimal points, plus the registered scan drive.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  Load;
  logic [4*DIGITS-1:0]   Value;
  logic [DIGITS-1:0]     DpMask;
  logic [7:0]            Seg;
  logic [DIGITS-1:0]     An;
  logic                  FrameTick;

  modport master (output Load, Value, DpMask, input Seg, An, FrameTick);
  modport slave  (input Load, Value, DpMask, output Seg, An, FrameTick);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment scan driver with shadow-loaded value and points.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits (never digit 0).
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  seg_scan_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0] AN_RST   = ~DIGITS'(1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                frame_tick_q, frame_tick_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tc;
  logic [3:0]          nib;
  logic                dp_bit;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                zero_above;
  logic                blank_sel;
`endif

  // Segment patterns a..g, active-low.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'b0000001;
      4'h1: hex_decode = 7'b1001111;
      4'h2: hex_decode = 7'b0010010;
      4'h3: hex_decode = 7'b0000110;
      4'h4: hex_decode = 7'b1001100;
      4'h5: hex_decode = 7'b0100100;
      4'h6: hex_decode = 7'b0100000;
      4'h7: hex_decode = 7'b0001111;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0000100;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b1100000;
      4'hC: hex_decode = 7'b0110001;
      4'hD: hex_decode = 7'b1000010;
      4'hE: hex_decode = 7'b0110000;
      default: hex_decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    val_d = val_q;
    dp_d  = dp_q;
    if (bus.Load) begin
      val_d = bus.Value;
      dp_d  = bus.DpMask;
    end

    tc    = (div_q == DIV_LAST);
    div_d = tc ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    frame_tick_d = tc && (idx_q == IDX_LAST);

    // Output stage works from the current index, so An and Seg share one cycle of latency.
    nib    = '0;
    dp_bit = 1'b0;
    an_d   = '1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    zero_above = 1'b1;
    blank_sel  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) blank_sel = zero_above;
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib     = val_q[4*i +: 4];
        dp_bit  = dp_q[i];
        an_d[i] = 1'b0;
      end
    end
    seg_d = {hex_decode(nib), ~dp_bit};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (blank_sel) seg_d[7:1] = 7'b1111111;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      dp_q         <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= 8'b11111110;
      an_q         <= AN_RST;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.Seg       = seg_q;
  assign bus.An        = an_q;
  assign bus.FrameTick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4.
module tb_seg_scan_driver;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  seg_scan_if #(.DIGITS(4)) bus ();

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .Clk   (clk),
    .Reset (reset_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for n edges, then release with Load low; returns sampled after last reset edge.
  task automatic do_reset(input int n);
    reset_n  = 1'b0;
    bus.Load = 1'b0;
    for (int i = 0; i < n; i++) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.Load   = 1'b1;
    bus.Value  = 16'hFFFF;
    bus.DpMask = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.Seg !== 8'b11111110) begin
      errors++; $display("FAIL reset_seg got=%b want=11111110", bus.Seg);
    end
    checks++;
    if (bus.An !== 4'b1110) begin
      errors++; $display("FAIL reset_an got=%b want=1110", bus.An);
    end
    checks++;
    if (bus.FrameTick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got=%b want=0", bus.FrameTick);
    end
    bus.Load = 1'b0;
    reset_n  = 1'b1;
    step();
    step();
    checks++;
    if (bus.Seg !== 8'b00000011) begin
      errors++; $display("FAIL release_seg got=%b want=00000011", bus.Seg);
    end
    checks++;
    if (bus.An !== 4'b1110) begin
      errors++; $display("FAIL release_an got=%b want=1110", bus.An);
    end
  endtask

  task automatic test_frame_tick();
    int cnt;
    int pos[2];
    cnt = 0;
    pos[0] = -1;
    pos[1] = -1;
    do_reset(1);
    for (int e = 1; e <= 32; e++) begin
      step();
      if (bus.FrameTick === 1'b1) begin
        if (cnt < 2) pos[cnt] = e;
        cnt++;
      end
    end
    checks++;
    if (cnt != 2) begin
      errors++; $display("FAIL tick_count got=%0d want=2", cnt);
    end
    checks++;
    if (pos[0] != 16) begin
      errors++; $display("FAIL tick_first got=%0d want=16", pos[0]);
    end
    checks++;
    if (pos[1] != 32) begin
      errors++; $display("FAIL tick_second got=%0d want=32", pos[1]);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp [4];
    logic [7:0] seg_exp[4];
    int k;
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{8'b01110001, 8'b00001101, 8'b00010000, 8'b10011111};
    do_reset(1);
    bus.Load   = 1'b1;
    bus.Value  = 16'h1A3F;
    bus.DpMask = 4'b0100;
    step();
    bus.Load = 1'b0;
    for (int e = 2; e <= 16; e++) begin
      step();
      k = (e - 1) / 4;
      checks++;
      if (bus.An !== an_exp[k] || bus.Seg !== seg_exp[k]) begin
        errors++;
        $display("FAIL scan_e%0d got an=%b seg=%b want an=%b seg=%b",
                 e, bus.An, bus.Seg, an_exp[k], seg_exp[k]);
      end
    end
  endtask

  task automatic test_load_on_tc();
    do_reset(1);
    bus.Load   = 1'b1;
    bus.Value  = 16'h0000;
    bus.DpMask = 4'b0000;
    step();
    bus.Load = 1'b0;
    for (int e = 2; e <= 7; e++) step();
    bus.Load  = 1'b1;
    bus.Value = 16'h8888;
    step();
    bus.Load = 1'b0;
    checks++;
    if (bus.Seg !== 8'b00000011 || bus.An !== 4'b1101) begin
      errors++; $display("FAIL tc_old_digit1 got an=%b seg=%b want an=1101 seg=00000011", bus.An, bus.Seg);
    end
    step();
    checks++;
    if (bus.Seg !== 8'b00000001 || bus.An !== 4'b1011) begin
      errors++; $display("FAIL tc_new_digit2 got an=%b seg=%b want an=1011 seg=00000001", bus.An, bus.Seg);
    end
    // Now at edge 9; mid-slot load of digit 2 after edge 10.
    step();
    bus.Load  = 1'b1;
    bus.Value = 16'h0300;
    step();
    bus.Load = 1'b0;
    checks++;
    if (bus.Seg !== 8'b00000001) begin
      errors++; $display("FAIL mid_load_edge got=%b want=00000001", bus.Seg);
    end
    step();
    checks++;
    if (bus.Seg !== 8'b00001101 || bus.An !== 4'b1011) begin
      errors++; $display("FAIL mid_load_seg got an=%b seg=%b want an=1011 seg=00001101", bus.An, bus.Seg);
    end
    step();
    checks++;
    if (bus.An !== 4'b0111) begin
      errors++; $display("FAIL mid_load_div got an=%b want=0111", bus.An);
    end
  endtask

  task automatic test_blank();
    logic [7:0] seg_exp[4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    seg_exp = '{8'b00000011, 8'b01001001, 8'b11111111, 8'b11111110};
`else
    seg_exp = '{8'b00000011, 8'b01001001, 8'b00000011, 8'b00000010};
`endif
    do_reset(1);
    bus.Load   = 1'b1;
    bus.Value  = 16'h0050;
    bus.DpMask = 4'b1000;
    step();
    bus.Load = 1'b0;
    for (int e = 2; e <= 16; e++) begin
      step();
      if (e % 4 == 0) begin
        checks++;
        if (bus.Seg !== seg_exp[e/4 - 1]) begin
          errors++; $display("FAIL blank_digit%0d got=%b want=%b", e/4 - 1, bus.Seg, seg_exp[e/4 - 1]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    bus.Load   = 1'b1;
    bus.Value  = 16'h4321;
    bus.DpMask = 4'b0000;
    step();
    bus.Load = 1'b0;
    for (int e = 2; e <= 10; e++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (bus.Seg !== 8'b11111110 || bus.An !== 4'b1110 || bus.FrameTick !== 1'b0) begin
      errors++; $display("FAIL midrst_state got an=%b seg=%b tick=%b want an=1110 seg=11111110 tick=0",
                         bus.An, bus.Seg, bus.FrameTick);
    end
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (bus.An !== 4'b1110) begin
        errors++; $display("FAIL midrst_slot_e%0d got an=%b want=1110", e, bus.An);
      end
      if (e == 2) begin
        checks++;
        if (bus.Seg !== 8'b00000011) begin
          errors++; $display("FAIL midrst_seg got=%b want=00000011", bus.Seg);
        end
      end
    end
    step();
    checks++;
    if (bus.An !== 4'b1101) begin
      errors++; $display("FAIL midrst_next got an=%b want=1101", bus.An);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    bus.Load   = 1'b0;
    bus.Value  = '0;
    bus.DpMask = '0;
    test_reset();
    test_frame_tick();
    test_scan();
    test_load_on_tc();
    test_blank();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
